// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the femtoRV32 multi-cycle control path.
// Holds the opcode[6:2] constants, the control FSM state type, the datapath
// select encodings, the trap cause encoding and the decoded instruction class.
package rv32_ctrl_pkg;

  // Major opcodes, IR[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StTrap
  } state_e;

  typedef enum logic [1:0] {
    PcPlus4 = 2'b00, PcImm = 2'b01, PcJalr = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    AluARs1 = 2'b00, AluAPc = 2'b01, AluAZero = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    AluOpAdd = 2'b00, AluOpBranch = 2'b01, AluOpFunct = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00, WbMem = 2'b01, WbPc4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    CauseNone = 2'b00, CauseIllegal = 2'b01, CauseBusTimeout = 2'b10
  } trap_cause_e;

  typedef enum logic [3:0] {
    ClsArithR, ClsArithI, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr,
    ClsLui, ClsAuipc, ClsSystem, ClsIllegal
  } instr_class_e;

endpackage

// File: rtl/rv32_main_decoder.sv
// Main opcode decoder: maps IR[6:2] to an instruction class.
// Purely combinational; also used by the single-cycle path.
// Ports:
//   opcode       in  5  IR[6:2]
//   instr_class  out    decoded class, ClsIllegal for unsupported opcodes
module rv32_main_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_e instr_class
);

  always_comb begin
    instr_class = ClsIllegal;
    case (opcode)
      OPC_OP:     instr_class = ClsArithR;
      OPC_OP_IMM: instr_class = ClsArithI;
      OPC_LOAD:   instr_class = ClsLoad;
      OPC_STORE:  instr_class = ClsStore;
      OPC_BRANCH: instr_class = ClsBranch;
      OPC_JAL:    instr_class = ClsJal;
      OPC_JALR:   instr_class = ClsJalr;
      OPC_LUI:    instr_class = ClsLui;
      OPC_AUIPC:  instr_class = ClsAuipc;
      OPC_SYSTEM: instr_class = ClsSystem;
      default:    instr_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle control FSM for femtoRV32.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a single wait-stated memory port and
// drives the datapath selects and strobes. Stops in HALT on SYSTEM and in TRAP
// on an illegal opcode or a memory access that exceeds WAIT_TIMEOUT wait cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode, funct3        fields of the latched instruction register
//   branch_taken          branch comparator result (used in EXEC)
//   mem_ready             current memory access completes this cycle
//   mem_req, mem_we       memory request / store qualifier
//   ir_we, pc_we, pc_src  instruction register and PC update control
//   alu_src_a/b, alu_op   ALU operand and operation selects
//   wb_sel, reg_we        register file writeback control
//   instret               one pulse per retired instruction
//   halted, trap,
//   trap_cause            sticky stop status
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter bit          EN_SYSTEM    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       reg_we,
  output logic       instret,
  output logic       halted,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int unsigned CntW =
      ($clog2(WAIT_TIMEOUT + 1) > 4) ? $clog2(WAIT_TIMEOUT + 1) : 4;
  // Only meaningful when WAIT_TIMEOUT > 0
  localparam logic [CntW-1:0] TimeoutLast = CntW'(WAIT_TIMEOUT - 1);

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  trap_cause_e     cause_q;
  instr_class_e    cls;
  logic            timeout;

  // funct3 is decoded by the ALU, not by the sequencer
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  rv32_main_decoder u_main_decoder (
    .opcode      (opcode),
    .instr_class (cls)
  );

  // Last allowed wait cycle of a FETCH/MEM access without ready
  assign timeout = (WAIT_TIMEOUT != 0) && !mem_ready && (wait_cnt_q == TimeoutLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      cause_q    <= CauseNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          wait_cnt_q <= '0;
        end
        StFetch: begin
          if (mem_ready) begin
            state_q    <= StDecode;
            wait_cnt_q <= '0;
          end else if (timeout) begin
            state_q <= StTrap;
            cause_q <= CauseBusTimeout;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StDecode: begin
          if (cls == ClsIllegal || (cls == ClsSystem && !EN_SYSTEM)) begin
            state_q <= StTrap;
            cause_q <= CauseIllegal;
          end else if (cls == ClsSystem) begin
            state_q <= StHalt;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          wait_cnt_q <= '0;
          case (cls)
            ClsLoad, ClsStore:         state_q <= StMem;
            ClsBranch, ClsJal, ClsJalr: state_q <= StFetch;
            default:                   state_q <= StWb;
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            state_q    <= (cls == ClsLoad) ? StWb : StFetch;
            wait_cnt_q <= '0;
          end else if (timeout) begin
            state_q <= StTrap;
            cause_q <= CauseBusTimeout;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StWb: begin
          state_q    <= StFetch;
          wait_cnt_q <= '0;
        end
        StHalt, StTrap: state_q <= state_q;
        default:        state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PcPlus4;
    alu_src_a = AluARs1;
    alu_src_b = 1'b0;
    alu_op    = AluOpAdd;
    wb_sel    = WbAlu;
    reg_we    = 1'b0;
    instret   = 1'b0;
    halted    = 1'b0;
    trap      = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      StExec: begin
        case (cls)
          ClsArithR: alu_op = AluOpFunct;
          ClsArithI: begin
            alu_op    = AluOpFunct;
            alu_src_b = 1'b1;
          end
          ClsLui: begin
            alu_src_a = AluAZero;
            alu_src_b = 1'b1;
          end
          ClsAuipc: begin
            alu_src_a = AluAPc;
            alu_src_b = 1'b1;
          end
          ClsLoad, ClsStore: alu_src_b = 1'b1;
          ClsBranch: begin
            alu_op  = AluOpBranch;
            pc_we   = 1'b1;
            pc_src  = branch_taken ? PcImm : PcPlus4;
            instret = 1'b1;
          end
          ClsJal: begin
            pc_src  = PcImm;
            pc_we   = 1'b1;
            reg_we  = 1'b1;
            wb_sel  = WbPc4;
            instret = 1'b1;
          end
          ClsJalr: begin
            pc_src    = PcJalr;
            alu_src_b = 1'b1;
            pc_we     = 1'b1;
            reg_we    = 1'b1;
            wb_sel    = WbPc4;
            instret   = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = (cls == ClsStore);
        // A store retires in MEM; a load retires in WB
        if (cls == ClsStore && mem_ready) begin
          pc_we   = 1'b1;
          instret = 1'b1;
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        wb_sel  = (cls == ClsLoad) ? WbMem : WbAlu;
        pc_we   = 1'b1;
        instret = 1'b1;
      end
      StHalt:  halted = 1'b1;
      StTrap:  trap   = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl. Outputs are packed into one vector
// and compared per cycle against hand-written expected vectors.
module tb_rv32_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       mem_ready;

  logic       mem_req, mem_we, ir_we, pc_we, alu_src_b, reg_we, instret, halted, trap;
  logic [1:0] pc_src, alu_src_a, alu_op, wb_sel, trap_cause;
  logic       t_mem_req, t_mem_we, t_ir_we, t_pc_we, t_alu_src_b, t_reg_we, t_instret;
  logic       t_halted, t_trap;
  logic [1:0] t_pc_src, t_alu_src_a, t_alu_op, t_wb_sel, t_trap_cause;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rv32_multicycle_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel),
    .reg_we(reg_we), .instret(instret), .halted(halted), .trap(trap),
    .trap_cause(trap_cause)
  );

  rv32_multicycle_ctrl #(.WAIT_TIMEOUT(4), .EN_SYSTEM(1'b1)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .ir_we(t_ir_we), .pc_we(t_pc_we),
    .pc_src(t_pc_src), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
    .alu_op(t_alu_op), .wb_sel(t_wb_sel), .reg_we(t_reg_we), .instret(t_instret),
    .halted(t_halted), .trap(t_trap), .trap_cause(t_trap_cause)
  );

  // {mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op, wb_sel,
  //  reg_we, instret, halted, trap, trap_cause}
  logic [18:0] obs, obs_to;
  assign obs = {mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
                wb_sel, reg_we, instret, halted, trap, trap_cause};
  assign obs_to = {t_mem_req, t_mem_we, t_ir_we, t_pc_we, t_pc_src, t_alu_src_a,
                   t_alu_src_b, t_alu_op, t_wb_sel, t_reg_we, t_instret, t_halted,
                   t_trap, t_trap_cause};

  localparam logic [18:0] NONE    = 19'd0;
  localparam logic [18:0] REQ     = 19'd1 << 18;
  localparam logic [18:0] WE      = 19'd1 << 17;
  localparam logic [18:0] IRW     = 19'd1 << 16;
  localparam logic [18:0] PCW     = 19'd1 << 15;
  localparam logic [18:0] PC_IMM  = 19'd1 << 13;
  localparam logic [18:0] PC_JALR = 19'd2 << 13;
  localparam logic [18:0] A_PC    = 19'd1 << 11;
  localparam logic [18:0] A_ZERO  = 19'd2 << 11;
  localparam logic [18:0] B_IMM   = 19'd1 << 10;
  localparam logic [18:0] OP_BR   = 19'd1 << 8;
  localparam logic [18:0] OP_FN   = 19'd2 << 8;
  localparam logic [18:0] WB_MEM  = 19'd1 << 6;
  localparam logic [18:0] WB_PC4  = 19'd2 << 6;
  localparam logic [18:0] RWE     = 19'd1 << 5;
  localparam logic [18:0] RET     = 19'd1 << 4;
  localparam logic [18:0] HLT     = 19'd1 << 3;
  localparam logic [18:0] TRP     = 19'd1 << 2;
  localparam logic [18:0] C_ILL   = 19'd1;
  localparam logic [18:0] C_BUS   = 19'd2;

  // Returns just after a rising edge with the DUT in IDLE: that period is cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #3;
    vectors++;
    if (obs !== NONE) begin
      miscompares++;
      $display("FAIL reset_async: got %05h want %05h", obs, NONE);
    end
    @(posedge clk); #1;
    vectors++;
    if (obs_to !== NONE) begin
      miscompares++;
      $display("FAIL reset_held: got %05h want %05h", obs_to, NONE);
    end
  endtask

  task automatic test_addi();
    logic [18:0] e [6];
    e = '{NONE, REQ | IRW, NONE, B_IMM | OP_FN, RWE | PCW | RET, REQ | IRW};
    opcode = 5'b00100;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== e[c]) begin
        miscompares++;
        $display("FAIL addi c%0d: got %05h want %05h", c, obs, e[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [18:0] e [9];
    logic [8:0]  rdy;
    e = '{NONE, REQ | IRW, NONE, B_IMM, REQ, REQ, REQ, RWE | WB_MEM | PCW | RET, REQ | IRW};
    rdy = 9'b111001111;  // bit c = mem_ready in cycle c; MEM waits in cycles 4,5
    opcode = 5'b00000;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      mem_ready = rdy[c];
      @(negedge clk);
      vectors++;
      if (obs !== e[c]) begin
        miscompares++;
        $display("FAIL lw c%0d: got %05h want %05h", c, obs, e[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [18:0] e [5];
    for (int t = 0; t < 2; t++) begin
      e = '{NONE, REQ | IRW, NONE, OP_BR | PCW | RET | ((t == 1) ? PC_IMM : NONE), REQ | IRW};
      opcode = 5'b11000;
      do_reset();
      branch_taken = (t == 1);
      for (int c = 0; c < 5; c++) begin
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== e[c]) begin
          miscompares++;
          $display("FAIL beq taken=%0d c%0d: got %05h want %05h", t, c, obs, e[c]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jalr();
    logic [18:0] e [5];
    e = '{NONE, REQ | IRW, NONE, PCW | PC_JALR | B_IMM | RWE | WB_PC4 | RET, REQ | IRW};
    opcode = 5'b11001;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== e[c]) begin
        miscompares++;
        $display("FAIL jalr c%0d: got %05h want %05h", c, obs, e[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  // EXEC-cycle outputs (cycle 3) for the remaining single-EXEC classes
  task automatic test_exec_classes();
    logic [4:0]  opc [4];
    logic [18:0] e [4];
    opc = '{5'b01100, 5'b01101, 5'b00101, 5'b11011};
    e = '{OP_FN, A_ZERO | B_IMM, A_PC | B_IMM, PCW | PC_IMM | RWE | WB_PC4 | RET};
    for (int i = 0; i < 4; i++) begin
      opcode = opc[i];
      do_reset();
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL exec opcode=%05b: got %05h want %05h", opc[i], obs, e[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [18:0] e [6];
    e = '{NONE, REQ | IRW, NONE, B_IMM, REQ | WE | PCW | RET, REQ | IRW};
    opcode = 5'b01000;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== e[c]) begin
        miscompares++;
        $display("FAIL sw c%0d: got %05h want %05h", c, obs, e[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stops();
    logic [18:0] e;
    for (int t = 0; t < 2; t++) begin
      opcode = (t == 0) ? 5'b11111 : 5'b11100;
      do_reset();
      for (int c = 0; c < 13; c++) begin
        mem_ready = 1'b1;
        e = (c == 1) ? (REQ | IRW) : (c >= 3) ? ((t == 0) ? (TRP | C_ILL) : HLT) : NONE;
        @(negedge clk);
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL %s c%0d: got %05h want %05h", (t == 0) ? "illegal" : "halt",
                   c, obs, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_timeout();
    logic [18:0] e_to, e_main;
    opcode = 5'b00100;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      mem_ready = 1'b0;
      e_to = (c == 0) ? NONE : (c <= 4) ? REQ : (TRP | C_BUS);
      e_main = (c == 0) ? NONE : REQ;
      @(negedge clk);
      vectors++;
      if (obs_to !== e_to) begin
        miscompares++;
        $display("FAIL timeout4 c%0d: got %05h want %05h", c, obs_to, e_to);
      end
      vectors++;
      if (obs !== e_main) begin
        miscompares++;
        $display("FAIL timeout15 c%0d: got %05h want %05h", c, obs, e_main);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [18:0] e [5];
    e = '{NONE, REQ | IRW, NONE, B_IMM, REQ | WE};
    opcode = 5'b01000;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c < 4);
      @(negedge clk);
      vectors++;
      if (obs !== e[c]) begin
        miscompares++;
        $display("FAIL sw_wait c%0d: got %05h want %05h", c, obs, e[c]);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (obs !== (REQ | WE)) begin
      miscompares++;
      $display("FAIL sw_pre_rst: got %05h want %05h", obs, REQ | WE);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== NONE) begin
      miscompares++;
      $display("FAIL rst_mid_mem: got %05h want %05h", obs, NONE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== NONE) begin
      miscompares++;
      $display("FAIL idle_after_rst: got %05h want %05h", obs, NONE);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (obs !== (REQ | IRW)) begin
      miscompares++;
      $display("FAIL fetch_after_rst: got %05h want %05h", obs, REQ | IRW);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 5'b00000;
    funct3 = 3'b000;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_lw();
    test_branch();
    test_jalr();
    test_exec_classes();
    test_sw();
    test_stops();
    test_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
